// File: rtl/decode_stage_riscv_if.sv
// Fetch-to-decode beat channel: {pc, instr} with a valid/ready handshake.
// The fetch unit drives through the master modport and the decode stage receives through the slave modport.
interface decode_stage_riscv_if;
    logic        fetch_valid_i;
    logic [31:0] fetch_instr_i;
    logic [31:0] fetch_pc_i;
    logic        fetch_ready_o;

    modport master (
        output fetch_valid_i,
        output fetch_instr_i,
        output fetch_pc_i,
        input  fetch_ready_o
    );

    modport slave (
        input  fetch_valid_i,
        input  fetch_instr_i,
        input  fetch_pc_i,
        output fetch_ready_o
    );
endinterface

// File: rtl/decode_stage_riscv.sv
// Registered RV32I+Zicsr decode stage fed by an IBUF_DEPTH-entry instruction buffer.
// Features:
//   - Fetch beats bypass the buffer when it is empty and the output register can load.
//   - Flush discards every buffered and decoded instruction.
//   - An interrupt replaces the presented bundle in place with an interrupt slot.
// Optional feature macro: DECODE_RV32M_EN. When it is defined, OP with funct7=0000001 decodes as an M-extension op.
module decode_stage_riscv #(
    parameter  int unsigned IBUF_DEPTH = 2,
    localparam int unsigned CNT_W      = $clog2(IBUF_DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 arstn_i,
    decode_stage_riscv_if.slave  fetch_if,
    input  logic                 flush_i,
    input  logic                 int_i,
    output logic                 int_ack_o,
    output logic                 dec_valid_o,
    input  logic                 dec_ready_i,
    output logic [31:0]          dec_pc_o,
    output logic [31:0]          dec_instr_o,
    output logic [1:0]           ex_op_a_sel_o,
    output logic [2:0]           ex_op_b_sel_o,
    output logic [4:0]           alu_op_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [2:0]           mem_size_o,
    output logic                 gpr_we_o,
    output logic                 wb_src_sel_o,
    output logic                 illegal_instr_o,
    output logic                 branch_o,
    output logic                 jal_o,
    output logic [1:0]           jalr_o,
    output logic                 csr_o,
    output logic [2:0]           csr_op_o,
    output logic                 mret_o,
    output logic [CNT_W-1:0]     ibuf_count_o
);
    localparam int unsigned PTR_W = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [1:0] A_CURR_PC = 2'd1;
    localparam logic [1:0] A_ZERO    = 2'd2;
    localparam logic [2:0] B_IMM_I   = 3'd1;
    localparam logic [2:0] B_IMM_U   = 3'd2;
    localparam logic [2:0] B_IMM_S   = 3'd3;
    localparam logic [2:0] B_INCR    = 3'd4;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic [1:0] a_sel;
        logic [2:0] b_sel;
        logic [4:0] alu_op;
        logic       mem_req;
        logic       mem_we;
        logic [2:0] mem_size;
        logic       gpr_we;
        logic       wb_src;
        logic       illegal;
        logic       branch;
        logic       jal;
        logic [1:0] jalr;
        logic       csr;
        logic [2:0] csr_op;
        logic       mret;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [31:0] w);
        ctrl_t      c;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = w[14:12];
        f7 = w[31:25];
        c  = '0;
        case (w[6:0])
            OPC_LOAD: begin
                c.b_sel   = B_IMM_I;
                c.mem_req = 1'b1;
                c.gpr_we  = 1'b1;
                c.wb_src  = 1'b1;
                case (f3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: c.mem_size = f3;
                    default:                                c.illegal  = 1'b1;
                endcase
            end
            OPC_STORE: begin
                c.b_sel   = B_IMM_S;
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                case (f3)
                    3'b000, 3'b001, 3'b010: c.mem_size = f3;
                    default:                c.illegal  = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                c.b_sel  = B_IMM_I;
                c.gpr_we = 1'b1;
                c.alu_op = {2'b00, f3};
                if (f3 == 3'b001 && f7 != 7'd0) begin
                    c.illegal = 1'b1;
                end else if (f3 == 3'b101) begin
                    if (f7 == F7_ALT)     c.alu_op  = {2'b01, f3};
                    else if (f7 != 7'd0)  c.illegal = 1'b1;
                end
            end
            OPC_OP: begin
                c.gpr_we = 1'b1;
                case (f7)
                    7'd0:   c.alu_op = {2'b00, f3};
                    F7_ALT: begin
                        if (f3 == 3'b000 || f3 == 3'b101) c.alu_op  = {2'b01, f3};
                        else                              c.illegal = 1'b1;
                    end
`ifdef DECODE_RV32M_EN
                    F7_MULDIV: c.alu_op = {2'b10, f3};
`else
                    F7_MULDIV: c.illegal = 1'b1;
`endif
                    default: c.illegal = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                c.branch = 1'b1;
                c.alu_op = {2'b11, f3};
                if (f3[2:1] == 2'b01) c.illegal = 1'b1;
            end
            OPC_JAL: begin
                c.a_sel  = A_CURR_PC;
                c.b_sel  = B_INCR;
                c.gpr_we = 1'b1;
                c.jal    = 1'b1;
            end
            OPC_JALR: begin
                c.a_sel  = A_CURR_PC;
                c.b_sel  = B_INCR;
                c.gpr_we = 1'b1;
                c.jalr   = 2'd1;
                if (f3 != 3'b000) c.illegal = 1'b1;
            end
            OPC_SYSTEM: begin
                case (f3)
                    3'b000:  begin c.mret = 1'b1; c.jalr = 2'd2; end
                    3'b001:  begin c.csr = 1'b1; c.csr_op = 3'd1; c.gpr_we = 1'b1; end
                    3'b010:  begin c.csr = 1'b1; c.csr_op = 3'd3; c.gpr_we = 1'b1; end
                    3'b011:  begin c.csr = 1'b1; c.csr_op = 3'd2; c.gpr_we = 1'b1; end
                    default: c.illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                c.a_sel  = A_ZERO;
                c.b_sel  = B_IMM_U;
                c.gpr_we = 1'b1;
            end
            OPC_AUIPC: begin
                c.a_sel  = A_CURR_PC;
                c.b_sel  = B_IMM_U;
                c.gpr_we = 1'b1;
            end
            OPC_MISC_MEM: ;
            default: c.illegal = 1'b1;
        endcase
        if (c.illegal) begin
            c.mem_req = 1'b0;
            c.gpr_we  = 1'b0;
        end
        return c;
    endfunction

    // Converts a bundle into an interrupt slot that jumps to MTVEC.
    function automatic ctrl_t int_slot(input ctrl_t c);
        ctrl_t r;
        r           = c;
        r.jalr      = 2'd3;
        r.csr_op[2] = 1'b1;
        r.mem_req   = 1'b0;
        r.gpr_we    = 1'b0;
        r.illegal   = 1'b0;
        return r;
    endfunction

    logic [31:0]      pc_mem    [IBUF_DEPTH];
    logic [31:0]      instr_mem [IBUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             dec_valid_q, int_slot_q, int_blk_q;
    logic [31:0]      pc_q, instr_q;
    ctrl_t            ctrl_q;

    logic             fetch_ready, push_acc, loadable, src_avail, load, pop, push_fifo, inject, int_ack;
    logic [31:0]      src_pc, src_instr;
    ctrl_t            src_ctrl;

    // Handshake, load-source selection and interrupt qualification.
    always_comb begin
        fetch_ready = !flush_i && (count_q < CNT_W'(IBUF_DEPTH));
        push_acc    = fetch_if.fetch_valid_i && fetch_ready;
        loadable    = !dec_valid_q || dec_ready_i;
        src_avail   = (count_q != '0) || push_acc;
        src_pc      = (count_q != '0) ? pc_mem[rd_ptr_q]    : fetch_if.fetch_pc_i;
        src_instr   = (count_q != '0) ? instr_mem[rd_ptr_q] : fetch_if.fetch_instr_i;
        src_ctrl    = decode(src_instr);
        load        = loadable && src_avail;
        pop         = load && (count_q != '0);
        push_fifo   = push_acc && !(load && (count_q == '0));
        // A bundle being accepted this cycle has already gone to EX, so the slot lands on its successor.
        inject      = int_i && !int_blk_q && !int_slot_q && dec_valid_q && !flush_i
                      && (!dec_ready_i || src_avail);
        int_ack     = int_slot_q && dec_ready_i && !flush_i;
    end

    // Buffer storage; contents are qualified by the occupancy counter.
    always_ff @(posedge clk_i) begin
        if (push_fifo && !flush_i && !inject) begin
            pc_mem[wr_ptr_q]    <= fetch_if.fetch_pc_i;
            instr_mem[wr_ptr_q] <= fetch_if.fetch_instr_i;
        end
    end

    // Buffer pointers and occupancy; flush and interrupt injection empty the buffer.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i || inject) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_fifo) wr_ptr_q <= (wr_ptr_q == PTR_W'(IBUF_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)       rd_ptr_q <= (rd_ptr_q == PTR_W'(IBUF_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push_fifo) - CNT_W'(pop);
        end
    end

    // Output bundle register with flush > interrupt > load priority.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            dec_valid_q <= 1'b0;
            int_slot_q  <= 1'b0;
            int_blk_q   <= 1'b0;
            pc_q        <= '0;
            instr_q     <= '0;
            ctrl_q      <= '0;
        end else begin
            if (int_ack)     int_blk_q <= 1'b1;
            else if (!int_i) int_blk_q <= 1'b0;

            if (flush_i) begin
                dec_valid_q <= 1'b0;
                int_slot_q  <= 1'b0;
            end else if (inject) begin
                dec_valid_q <= 1'b1;
                int_slot_q  <= 1'b1;
                if (dec_ready_i) begin
                    pc_q    <= src_pc;
                    instr_q <= src_instr;
                    ctrl_q  <= int_slot(src_ctrl);
                end else begin
                    ctrl_q  <= int_slot(ctrl_q);
                end
            end else if (load) begin
                dec_valid_q <= 1'b1;
                int_slot_q  <= 1'b0;
                pc_q        <= src_pc;
                instr_q     <= src_instr;
                ctrl_q      <= src_ctrl;
            end else if (dec_ready_i) begin
                dec_valid_q <= 1'b0;
                int_slot_q  <= 1'b0;
            end
        end
    end

    assign fetch_if.fetch_ready_o = fetch_ready;
    assign int_ack_o       = int_ack;
    assign dec_valid_o     = dec_valid_q;
    assign dec_pc_o        = pc_q;
    assign dec_instr_o     = instr_q;
    assign ex_op_a_sel_o   = ctrl_q.a_sel;
    assign ex_op_b_sel_o   = ctrl_q.b_sel;
    assign alu_op_o        = ctrl_q.alu_op;
    assign mem_req_o       = ctrl_q.mem_req;
    assign mem_we_o        = ctrl_q.mem_we;
    assign mem_size_o      = ctrl_q.mem_size;
    assign gpr_we_o        = ctrl_q.gpr_we;
    assign wb_src_sel_o    = ctrl_q.wb_src;
    assign illegal_instr_o = ctrl_q.illegal;
    assign branch_o        = ctrl_q.branch;
    assign jal_o           = ctrl_q.jal;
    assign jalr_o          = ctrl_q.jalr;
    assign csr_o           = ctrl_q.csr;
    assign csr_op_o        = ctrl_q.csr_op;
    assign mret_o          = ctrl_q.mret;
    assign ibuf_count_o    = count_q;
endmodule

// File: tb/tb_decode_stage_riscv.sv
// Testbench for decode_stage_riscv: directed scenarios plus randomized traffic against a queue-based reference.
module tb_decode_stage_riscv;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [1:0] a;
        logic [2:0] b;
        logic [4:0] alu;
        logic       mreq;
        logic       mwe;
        logic [2:0] msz;
        logic       gwe;
        logic       wb;
        logic       ill;
        logic       br;
        logic       jal;
        logic [1:0] jalr;
        logic       csr;
        logic [2:0] cop;
        logic       mret;
    } exp_t;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    decode_stage_riscv_if fif();
    logic          flush, irq, irq_ack, dv, dr;
    logic [31:0]   dpc, dins;
    logic [1:0]    a_sel, jalr;
    logic [2:0]    b_sel, msz, cop;
    logic [4:0]    alu;
    logic          mreq, mwe, gwe, wb, ill, br, jal, csr, mret;
    logic [CW-1:0] cnt;

    decode_stage_riscv #(.IBUF_DEPTH(DEPTH)) dut (
        .clk_i(clk), .arstn_i(arstn), .fetch_if(fif),
        .flush_i(flush), .int_i(irq), .int_ack_o(irq_ack),
        .dec_valid_o(dv), .dec_ready_i(dr), .dec_pc_o(dpc), .dec_instr_o(dins),
        .ex_op_a_sel_o(a_sel), .ex_op_b_sel_o(b_sel), .alu_op_o(alu),
        .mem_req_o(mreq), .mem_we_o(mwe), .mem_size_o(msz), .gpr_we_o(gwe),
        .wb_src_sel_o(wb), .illegal_instr_o(ill), .branch_o(br), .jal_o(jal),
        .jalr_o(jalr), .csr_o(csr), .csr_op_o(cop), .mret_o(mret), .ibuf_count_o(cnt)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0] q_pc[$];
    logic [31:0] q_in[$];
    logic        m_valid = 1'b0, m_slot = 1'b0, m_blk = 1'b0, last_ack = 1'b0;
    logic [31:0] m_pc = '0, m_instr = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Spec-level decode rules, written as legality predicates per opcode.
    function automatic exp_t ref_dec(input logic [31:0] w);
        exp_t       e;
        logic       bad;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        e = '0; bad = 1'b0;
        opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        if (opc == 7'h03) begin
            e.b = 3'd1; e.mreq = 1'b1; e.gwe = 1'b1; e.wb = 1'b1;
            if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) e.msz = f3; else bad = 1'b1;
        end else if (opc == 7'h23) begin
            e.b = 3'd3; e.mreq = 1'b1; e.mwe = 1'b1;
            if (f3 <= 3'd2) e.msz = f3; else bad = 1'b1;
        end else if (opc == 7'h13) begin
            e.b = 3'd1; e.gwe = 1'b1; e.alu = {2'b00, f3};
            if (f3 == 3'd1) bad = (f7 != 7'h00);
            if (f3 == 3'd5) begin
                if (f7 == 7'h20) e.alu = {2'b01, f3};
                else bad = (f7 != 7'h00);
            end
        end else if (opc == 7'h33) begin
            e.gwe = 1'b1;
            if (f7 == 7'h00) e.alu = {2'b00, f3};
            else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) e.alu = {2'b01, f3};
`ifdef DECODE_RV32M_EN
            else if (f7 == 7'h01) e.alu = {2'b10, f3};
`endif
            else bad = 1'b1;
        end else if (opc == 7'h63) begin
            e.br = 1'b1; e.alu = {2'b11, f3};
            bad = (f3 == 3'd2 || f3 == 3'd3);
        end else if (opc == 7'h6F) begin
            e.a = 2'd1; e.b = 3'd4; e.gwe = 1'b1; e.jal = 1'b1;
        end else if (opc == 7'h67) begin
            e.a = 2'd1; e.b = 3'd4; e.gwe = 1'b1; e.jalr = 2'd1;
            bad = (f3 != 3'd0);
        end else if (opc == 7'h73) begin
            if (f3 == 3'd0) begin e.mret = 1'b1; e.jalr = 2'd2; end
            else if (f3 <= 3'd3) begin
                e.csr = 1'b1; e.gwe = 1'b1;
                e.cop = (f3 == 3'd1) ? 3'd1 : (f3 == 3'd2) ? 3'd3 : 3'd2;
            end else bad = 1'b1;
        end else if (opc == 7'h37) begin
            e.a = 2'd2; e.b = 3'd2; e.gwe = 1'b1;
        end else if (opc == 7'h17) begin
            e.a = 2'd1; e.b = 3'd2; e.gwe = 1'b1;
        end else if (opc != 7'h0F) begin
            bad = 1'b1;
        end
        if (bad) begin e.ill = 1'b1; e.mreq = 1'b0; e.gwe = 1'b0; end
        return e;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 11))
            0: w[6:0] = 7'h03;  1: w[6:0] = 7'h23;  2: w[6:0] = 7'h13;  3: w[6:0] = 7'h33;
            4: w[6:0] = 7'h63;  5: w[6:0] = 7'h6F;  6: w[6:0] = 7'h67;  7: w[6:0] = 7'h73;
            8: w[6:0] = 7'h37;  9: w[6:0] = 7'h17; 10: w[6:0] = 7'h0F;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        return w;
    endfunction

    // One clock cycle: drive, compare against the reference, then advance the reference.
    task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic rdy, input logic fl, input logic ir);
        exp_t e;
        logic exp_rdy, exp_ack, acc, take;
        @(negedge clk);
        fif.fetch_valid_i = fv; fif.fetch_pc_i = pc; fif.fetch_instr_i = ins;
        dr = rdy; flush = fl; irq = ir;
        #1;
        exp_rdy = !fl && (q_pc.size() < DEPTH);
        exp_ack = m_slot && rdy && !fl;
        check("fetch_ready", 32'(fif.fetch_ready_o), 32'(exp_rdy));
        check("int_ack", 32'(irq_ack), 32'(exp_ack));
        check("dec_valid", 32'(dv), 32'(m_valid));
        check("ibuf_count", 32'(cnt), 32'(q_pc.size()));
        if (m_valid) begin
            e = ref_dec(m_instr);
            if (m_slot) begin
                e.jalr = 2'd3; e.cop[2] = 1'b1; e.mreq = 1'b0; e.gwe = 1'b0; e.ill = 1'b0;
            end
            check("dec_pc", dpc, m_pc);
            check("dec_instr", dins, m_instr);
            check("a_sel", 32'(a_sel), 32'(e.a));
            check("b_sel", 32'(b_sel), 32'(e.b));
            check("alu_op", 32'(alu), 32'(e.alu));
            check("mem_req", 32'(mreq), 32'(e.mreq));
            check("mem_we", 32'(mwe), 32'(e.mwe));
            check("mem_size", 32'(msz), 32'(e.msz));
            check("gpr_we", 32'(gwe), 32'(e.gwe));
            check("wb_src", 32'(wb), 32'(e.wb));
            check("illegal", 32'(ill), 32'(e.ill));
            check("branch", 32'(br), 32'(e.br));
            check("jal", 32'(jal), 32'(e.jal));
            check("jalr", 32'(jalr), 32'(e.jalr));
            check("csr", 32'(csr), 32'(e.csr));
            check("csr_op", 32'(cop), 32'(e.cop));
            check("mret", 32'(mret), 32'(e.mret));
        end
        acc = fv && exp_rdy;
        if (fl) begin
            q_pc.delete(); q_in.delete(); m_valid = 1'b0; m_slot = 1'b0;
        end else begin
            take = ir && !m_blk && !m_slot && m_valid && (!rdy || q_pc.size() > 0 || acc);
            if (acc) begin q_pc.push_back(pc); q_in.push_back(ins); end
            if (m_valid && rdy) begin m_valid = 1'b0; m_slot = 1'b0; end
            if (!m_valid && q_pc.size() > 0) begin
                m_pc = q_pc.pop_front(); m_instr = q_in.pop_front(); m_valid = 1'b1;
            end
            if (take) begin m_slot = 1'b1; q_pc.delete(); q_in.delete(); end
        end
        if (exp_ack) m_blk = 1'b1;
        else if (!ir) m_blk = 1'b0;
        last_ack = exp_ack;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        arstn = 1'b0;
        fif.fetch_valid_i = 1'b0; dr = 1'b0; flush = 1'b0; irq = 1'b0;
        #1;
        check("rst_dec_valid", 32'(dv), 32'd0);
        check("rst_count", 32'(cnt), 32'd0);
        check("rst_int_ack", 32'(irq_ack), 32'd0);
        check("rst_pc", dpc, 32'd0);
        check("rst_bundle", {alu, a_sel, b_sel, mreq, gwe, ill, jalr, cop}, 32'd0);
        q_pc.delete(); q_in.delete();
        m_valid = 1'b0; m_slot = 1'b0; m_blk = 1'b0; last_ack = 1'b0;
        @(negedge clk);
        arstn = 1'b1;
    endtask

    initial begin
        logic irq_req;
        fif.fetch_valid_i = 1'b0; fif.fetch_pc_i = '0; fif.fetch_instr_i = '0;
        dr = 1'b0; flush = 1'b0; irq = 1'b0;
        do_reset();

        // ADDI x1,x0,5 issues one cycle after acceptance.
        step(1'b1, 32'h0, 32'h00500093, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("addi_valid", 32'(dv), 32'd1);
        check("addi_alu", 32'(alu), 32'd0);
        check("addi_gpr_we", 32'(gwe), 32'd1);
        check("addi_b_sel", 32'(b_sel), 32'd1);

        // Stall with three beats: buffer fills, then drains in order.
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 32'(4 * k), 32'h00500093, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("stall_count", 32'(cnt), 32'd2);
        check("stall_ready", 32'(fif.fetch_ready_o), 32'd0);
        check("stall_pc", dpc, 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("order_pc4", dpc, 32'h4);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("order_pc8", dpc, 32'h8);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush with a full buffer and a valid bundle.
        for (int k = 0; k < 3; k++) step(1'b1, 32'h10 + 32'(4 * k), 32'h00000013, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h99, 32'h00000013, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("flush_count", 32'(cnt), 32'd0);
        check("flush_valid", 32'(dv), 32'd0);
        step(1'b1, 32'h20, 32'h00500093, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("post_flush_valid", 32'(dv), 32'd1);
        check("post_flush_pc", dpc, 32'h20);

        // Interrupt replaces a stalled LW at pc 0x40.
        step(1'b1, 32'h40, 32'h00002083, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("int_jalr", 32'(jalr), 32'd3);
        check("int_csr_op2", 32'(cop[2]), 32'd1);
        check("int_mem_req", 32'(mreq), 32'd0);
        check("int_pc", dpc, 32'h40);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        check("int_ack_pulse", 32'(irq_ack), 32'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Illegal encodings.
        step(1'b1, 32'h50, 32'h00000000, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("ill_zero", 32'(ill), 32'd1);
        step(1'b1, 32'h54, 32'h00002063, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("ill_branch010", 32'(ill), 32'd1);
        step(1'b1, 32'h58, 32'h02208033, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
`ifdef DECODE_RV32M_EN
        check("mul_legal", 32'(ill), 32'd0);
        check("mul_alu", 32'(alu), 32'h10);
`else
        check("mul_illegal", 32'(ill), 32'd1);
`endif
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with interrupts held until acknowledged.
        irq_req = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            if (i == 600) begin
                do_reset();
                irq_req = 1'b0;
            end
            if (!irq_req && $urandom_range(0, 14) == 0) irq_req = 1'b1;
            step($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, rnd_instr(),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0, irq_req);
            if (last_ack) irq_req = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
